microbot_cmd_rx: RTL and testbench

//   Microbot-side receiver for the serial command link driven by the microbot controller.

---
 rtl/microbot_cmd_rx.sv | 176 +++++++++++++++++
 tb/tb_microbot_cmd_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/microbot_cmd_rx.sv
// Serial command receiver: start, DATA_BITS LSB-first, optional even parity, stop.
// Define MICROBOT_RX_PARITY_EN to add the parity bit, the PARITY state and parity_err.
module microbot_cmd_rx #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] cmd_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy,
  input  logic                 err_clr
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [DIV_W-1:0] HALF_M1  = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] FULL_M1  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MICROBOT_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state;
  logic                 rx_s1;
  logic                 rxs;
  logic [DIV_W-1:0]     div;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 wait_high;
`ifdef MICROBOT_RX_PARITY_EN
  logic                 par_bad;
`endif

  logic sample;
  assign sample = (div == FULL_M1);

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rx_in;
      rxs   <= rx_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      div        <= '0;
      bit_cnt    <= '0;
      // NOTE: the shift register is reset too, so cmd_data never loads X after a short frame.
      shreg      <= '0;
      wait_high  <= 1'b0;
      cmd_data   <= '0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
`ifdef MICROBOT_RX_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates let later statements override earlier ones in this
      // block, so a flag set wins over err_clr and a load wins over the accept clear.
      if (err_clr) begin
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
        overrun    <= 1'b0;
      end
      if (cmd_valid && cmd_ready) cmd_valid <= 1'b0;

      if (!ena) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (wait_high) begin
              if (rxs) wait_high <= 1'b0;
            end else if (!rxs) begin
              state   <= S_START;
              busy    <= 1'b1;
              div     <= '0;
              bit_cnt <= '0;
            end
          end
          S_START: begin
            if (div == HALF_M1) begin
              div <= '0;
              if (rxs) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= S_DATA;
              end
            end else begin
              div <= div + 1'b1;
            end
          end
          S_DATA: begin
            if (sample) begin
              div     <= '0;
              shreg   <= {rxs, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
`ifdef MICROBOT_RX_PARITY_EN
              if (bit_cnt == LAST_BIT) state <= S_PARITY;
`else
              if (bit_cnt == LAST_BIT) state <= S_STOP;
`endif
            end else begin
              div <= div + 1'b1;
            end
          end
`ifdef MICROBOT_RX_PARITY_EN
          S_PARITY: begin
            if (sample) begin
              div     <= '0;
              par_bad <= rxs ^ (^shreg);
              state   <= S_STOP;
            end else begin
              div <= div + 1'b1;
            end
          end
`endif
          S_STOP: begin
            if (sample) begin
              div   <= '0;
              state <= S_IDLE;
              busy  <= 1'b0;
              if (!rxs) begin
                // A low stop bit may be a break; ignore the line until it returns high.
                frame_err <= 1'b1;
                wait_high <= 1'b1;
              end else begin
`ifdef MICROBOT_RX_PARITY_EN
                if (par_bad) parity_err <= 1'b1;
                else
`endif
                if (cmd_valid && !cmd_ready) begin
                  overrun <= 1'b1;
                end else begin
                  cmd_data  <= shreg;
                  cmd_valid <= 1'b1;
                end
              end
            end else begin
              div <= div + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_microbot_cmd_rx.sv
// Directed bench for microbot_cmd_rx; honours MICROBOT_RX_PARITY_EN for frame length.
module tb_microbot_cmd_rx;

  localparam int CLK_DIV = 16;
`ifdef MICROBOT_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME     = CLK_DIV * NB;
  // Edge (counted from the tick that drives the start bit) on which the stop bit is sampled.
  localparam int STOP_EDGE = 3 + CLK_DIV / 2 + CLK_DIV * (NB - 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;
  logic       err_clr = 1'b0;

  int vectors = 0;
  int errs = 0;

  microbot_cmd_rx #(.CLK_DIV(CLK_DIV), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx_in(rx_in),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun),
    .busy(busy), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives ncyc clocks of a frame; with accept set, cmd_ready is high only on the stop-sample edge.
  task automatic send(input logic [7:0] d, input logic stop_b, input logic par_good,
                      input logic accept, input int ncyc);
    logic [10:0] fb;
    fb = 11'h7ff;
    fb[0] = 1'b0;
    fb[8:1] = d;
`ifdef MICROBOT_RX_PARITY_EN
    fb[9]  = (^d) ^ ~par_good;
    fb[10] = stop_b;
`else
    fb[9]  = stop_b;
`endif
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      rx_in = fb[c / CLK_DIV];
      if (accept) cmd_ready = (c == STOP_EDGE - 1);
    end
  endtask

  task automatic pulse_ready();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check("rst_valid", cmd_valid, 0);
    check("rst_data", cmd_data, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {frame_err, parity_err, overrun}, 0);
    rst_n = 1'b1;
    repeat (4) tick();

    send(8'hA5, 1'b1, 1'b1, 1'b0, FRAME);
    check("a5_valid", cmd_valid, 1);
    check("a5_data", cmd_data, 8'hA5);
    check("a5_flags", {frame_err, parity_err, overrun}, 0);
    check("a5_busy", busy, 0);
    pulse_ready();
    check("a5_consumed", cmd_valid, 0);
    check("a5_data_hold", cmd_data, 8'hA5);

    send(8'h3C, 1'b0, 1'b1, 1'b0, FRAME);
    check("ferr_set", frame_err, 1);
    check("ferr_no_valid", cmd_valid, 0);
    repeat (40) tick();
    check("break_no_start", busy, 0);
    rx_in = 1'b1;
    repeat (4) tick();
    send(8'h01, 1'b1, 1'b1, 1'b0, FRAME);
    check("x01_valid", cmd_valid, 1);
    check("x01_data", cmd_data, 8'h01);
    check("ferr_sticky", frame_err, 1);
    pulse_clr();
    check("ferr_clr", frame_err, 0);
    pulse_ready();
    check("x01_consumed", cmd_valid, 0);

`ifdef MICROBOT_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0, 1'b0, FRAME);
    check("perr_set", parity_err, 1);
    check("perr_no_valid", cmd_valid, 0);
    pulse_clr();
    check("perr_clr", parity_err, 0);
`endif

    send(8'h11, 1'b1, 1'b1, 1'b0, FRAME);
    send(8'h22, 1'b1, 1'b1, 1'b0, FRAME);
    check("ovr_data_kept", cmd_data, 8'h11);
    check("ovr_flag", overrun, 1);
    check("ovr_valid", cmd_valid, 1);
    pulse_clr();
    check("ovr_clr", overrun, 0);
    send(8'h22, 1'b1, 1'b1, 1'b1, FRAME);
    check("same_cyc_data", cmd_data, 8'h22);
    check("same_cyc_ovr", overrun, 0);
    check("same_cyc_valid", cmd_valid, 1);
    pulse_ready();
    check("x22_consumed", cmd_valid, 0);

    tick();
    rx_in = 1'b0;
    repeat (3) tick();
    rx_in = 1'b1;
    repeat (2) tick();
    check("glitch_busy", busy, 1);
    repeat (20) tick();
    check("glitch_idle", busy, 0);
    check("glitch_no_valid", cmd_valid, 0);
    check("glitch_no_flags", {frame_err, parity_err, overrun}, 0);

    send(8'hFF, 1'b1, 1'b1, 1'b0, CLK_DIV * 5 + CLK_DIV / 2);
    check("abort_busy", busy, 1);
    ena = 1'b0;
    tick();
    check("ena_off_busy", busy, 0);
    check("ena_off_valid", cmd_valid, 0);
    check("ena_off_flags", {frame_err, parity_err, overrun}, 0);
    rx_in = 1'b1;
    repeat (3) tick();
    ena = 1'b1;
    repeat (3) tick();
    send(8'h5A, 1'b1, 1'b1, 1'b0, FRAME);
    check("x5a_valid", cmd_valid, 1);
    check("x5a_data", cmd_data, 8'h5A);

    send(8'hFF, 1'b1, 1'b1, 1'b0, CLK_DIV * 5 + CLK_DIV / 2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", cmd_valid, 0);
    check("rst_mid_data", cmd_data, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    send(8'h5A, 1'b1, 1'b1, 1'b0, FRAME);
    check("x5a_again_valid", cmd_valid, 1);
    check("x5a_again_data", cmd_data, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
